// File: rtl/apb_rr_requester_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one two-slave APB bus.
// One transfer is in flight at a time. Wait states and timeout aborts end in a one-cycle response pulse.
module apb_rr_requester_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [1:0]                PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PSLVERR
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  int            idx;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[PW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
    if (state == IDLE && !PRESET && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      wait_cnt   <= '0;
      PSEL       <= 2'b00;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            PWRITE <= req_write[gnt_idx];
            PADDR  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            PWDATA <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            PSEL   <= req_addr[gnt_idx*ADDR_W + ADDR_W - 1] ? 2'b10 : 2'b01;
            owner  <= gnt_idx;
            ptr    <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            // A timeout abort reports an error with zero data, like a failed write.
            resp_err          <= PREADY ? PSLVERR : 1'b1;
            resp_rdata        <= (PREADY && !PWRITE) ? PRDATA : '0;
            PSEL              <= 2'b00;
            PENABLE           <= 1'b0;
            resp_valid[owner] <= 1'b1;
            state             <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_requester_arbiter.sv
// Directed bench: stimulus pushes expected APB setups and responses; a negedge monitor pops and checks them.
module tb_apb_rr_requester_arbiter;
  localparam int N = 3, AW = 9, DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [N-1:0]  req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  req_ready, resp_valid;
  logic [DW-1:0] resp_rdata, PWDATA, PRDATA;
  logic          resp_err, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0]    PSEL;
  logic [AW-1:0] PADDR;

  apb_rr_requester_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: PREADY rises after wait_cfg ACCESS cycles.
  int         wait_cfg = 0, acc_cnt = 0;
  logic [7:0] rd_cfg = 8'h00;
  logic       err_cfg = 1'b0;
  always @(posedge PCLK)
    if (PSEL != 2'b00 && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  assign PREADY  = (PSEL != 2'b00) && PENABLE && (acc_cnt >= wait_cfg);
  assign PRDATA  = PREADY ? rd_cfg : 8'h00;
  assign PSLVERR = PREADY & err_cfg;

  typedef struct { logic [1:0] psel; logic [8:0] addr; logic wr; logic [7:0] wd; int acc; } apb_exp_t;
  typedef struct { logic [2:0] owner; logic [7:0] rd; logic err; int lat; } resp_exp_t;
  apb_exp_t  apb_q[$];
  resp_exp_t resp_q[$];
  int        resp_cyc[$];
  apb_exp_t  cur;
  resp_exp_t er;
  bit        in_xfer = 0;
  int        acc_seen = 0, acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_xfer(input logic [2:0] own, input logic [8:0] a, input logic w, input logic [7:0] d,
                          input int acc, input logic [7:0] rd, input logic err, input bit has_resp);
    apb_exp_t ae;
    resp_exp_t re;
    ae.psel = a[8] ? 2'b10 : 2'b01; ae.addr = a; ae.wr = w; ae.wd = d; ae.acc = acc;
    apb_q.push_back(ae);
    if (has_resp) begin
      re.owner = own; re.rd = rd; re.err = err; re.lat = 2 + acc;
      resp_q.push_back(re);
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge PCLK);
    if (PRESET) begin
      in_xfer = 0;
    end else begin
      if ((req_valid & req_ready) != '0) acc_cyc = cyc;
      if (PSEL != 2'b00 && !PENABLE) begin
        if (apb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL apb_unexpected_setup: PSEL=%b PADDR=0x%0h with nothing expected", PSEL, PADDR);
        end else begin
          cur = apb_q.pop_front();
          chk("apb_psel", 32'(PSEL), 32'(cur.psel));
          chk("apb_paddr", 32'(PADDR), 32'(cur.addr));
          chk("apb_pwrite", 32'(PWRITE), 32'(cur.wr));
          if (cur.wr) chk("apb_pwdata", 32'(PWDATA), 32'(cur.wd));
          in_xfer = 1; acc_seen = 0;
        end
      end else if (in_xfer && PENABLE) begin
        acc_seen++;
        chk("apb_psel_held", 32'(PSEL), 32'(cur.psel));
      end else if (in_xfer && PSEL == 2'b00) begin
        if (cur.acc >= 0) chk("apb_access_cycles", 32'(acc_seen), 32'(cur.acc));
        in_xfer = 0;
      end
      if (resp_valid != '0) begin
        resp_cyc.push_back(cyc);
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: resp_valid=%b with nothing expected", resp_valid);
        end else begin
          er = resp_q.pop_front();
          chk("resp_owner", 32'(resp_valid), 32'(er.owner));
          chk("resp_rdata", 32'(resp_rdata), 32'(er.rd));
          chk("resp_err", 32'(resp_err), 32'(er.err));
          chk("resp_latency", 32'(cyc - acc_cyc), 32'(er.lat));
        end
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [8:0] a, input logic [7:0] d);
    int n = 0;
    req_write[i] = w; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_valid[i] = 1'b1;
    @(negedge PCLK);
    while (!req_ready[i] && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    if (!req_ready[i]) begin
      total++; bad++;
      $display("FAIL accept_timeout: requester %0d req_ready=%b after %0d cycles, required 1", i, req_ready, n);
    end
    @(posedge PCLK); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((apb_q.size() != 0 || resp_q.size() != 0 || in_xfer) && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    chk(nm, 32'(apb_q.size() + resp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", 32'(PWDATA), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge PCLK); #1 PRESET = 1'b0;

    // 1: zero-wait write from req0
    @(posedge PCLK); #1;
    exp_xfer(3'b001, 9'h005, 1'b1, 8'hA5, 1, 8'h00, 1'b0, 1);
    issue(0, 1'b1, 9'h005, 8'hA5);
    wait_idle("t1_idle");

    // 2: read from slave2 with three wait states
    @(posedge PCLK); #1;
    wait_cfg = 3; rd_cfg = 8'h3C;
    exp_xfer(3'b010, 9'h105, 1'b0, 8'h00, 4, 8'h3C, 1'b0, 1);
    issue(1, 1'b0, 9'h105, 8'h00);
    wait_idle("t2_idle");

    // 4: stuck slave, timeout after 16 ACCESS cycles
    @(posedge PCLK); #1;
    wait_cfg = 1000; rd_cfg = 8'hEE;
    exp_xfer(3'b100, 9'h0F0, 1'b0, 8'h00, 16, 8'h00, 1'b1, 1);
    issue(2, 1'b0, 9'h0F0, 8'h00);
    wait_idle("t4_idle");

    // 3: all three requesters contending, ptr back at 0
    @(posedge PCLK); #1;
    wait_cfg = 0;
    resp_cyc.delete();
    exp_xfer(3'b001, 9'h010, 1'b1, 8'h10, 1, 8'h00, 1'b0, 1);
    exp_xfer(3'b010, 9'h120, 1'b1, 8'h21, 1, 8'h00, 1'b0, 1);
    exp_xfer(3'b100, 9'h030, 1'b1, 8'h32, 1, 8'h00, 1'b0, 1);
    exp_xfer(3'b001, 9'h011, 1'b1, 8'h13, 1, 8'h00, 1'b0, 1);
    exp_xfer(3'b010, 9'h121, 1'b1, 8'h24, 1, 8'h00, 1'b0, 1);
    exp_xfer(3'b100, 9'h031, 1'b1, 8'h35, 1, 8'h00, 1'b0, 1);
    fork
      begin issue(0, 1'b1, 9'h010, 8'h10); issue(0, 1'b1, 9'h011, 8'h13); end
      begin issue(1, 1'b1, 9'h120, 8'h21); issue(1, 1'b1, 9'h121, 8'h24); end
      begin issue(2, 1'b1, 9'h030, 8'h32); issue(2, 1'b1, 9'h031, 8'h35); end
    join
    wait_idle("t3_idle");
    chk("rr_resp_count", 32'(resp_cyc.size()), 32'd6);
    for (int i = 1; i < resp_cyc.size(); i++)
      chk("rr_resp_gap", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd4);

    // 5: slave error on write, then a clean read from the same (sole) requester
    @(posedge PCLK); #1;
    err_cfg = 1'b1;
    exp_xfer(3'b001, 9'h0AA, 1'b1, 8'h11, 1, 8'h00, 1'b1, 1);
    issue(0, 1'b1, 9'h0AA, 8'h11);
    wait_idle("t5a_idle");
    @(posedge PCLK); #1;
    err_cfg = 1'b0; rd_cfg = 8'h77;
    exp_xfer(3'b001, 9'h1F0, 1'b0, 8'h00, 1, 8'h77, 1'b0, 1);
    issue(0, 1'b0, 9'h1F0, 8'h00);
    wait_idle("t5b_idle");

    // 6: reset during ACCESS kills the transfer and rewinds the pointer
    @(posedge PCLK); #1;
    wait_cfg = 1000;
    exp_xfer(3'b001, 9'h044, 1'b0, 8'h00, -1, 8'h00, 1'b0, 0);
    issue(0, 1'b0, 9'h044, 8'h00);
    begin
      int n = 0;
      @(negedge PCLK);
      while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
      chk("t6_in_access", 32'(PENABLE), 32'd1);
    end
    @(posedge PCLK); #1 PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("t6_psel_dropped", 32'(PSEL), 32'd0);
    chk("t6_penable_dropped", 32'(PENABLE), 32'd0);
    chk("t6_no_resp", 32'(resp_valid), 32'd0);
    repeat (8) @(negedge PCLK);
    wait_cfg = 0; rd_cfg = 8'h5A;
    @(posedge PCLK); #1;
    exp_xfer(3'b001, 9'h002, 1'b0, 8'h00, 1, 8'h5A, 1'b0, 1);
    exp_xfer(3'b010, 9'h102, 1'b0, 8'h00, 1, 8'h5A, 1'b0, 1);
    fork
      issue(0, 1'b0, 9'h002, 8'h00);
      issue(1, 1'b0, 9'h102, 8'h00);
    join
    wait_idle("t6_idle");

    repeat (4) @(negedge PCLK);
    chk("final_apb_q_empty", 32'(apb_q.size()), 32'd0);
    chk("final_resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
